// File: rtl/parity_serial_tx_pkg.sv
// Shared definitions for the parity serial link (TX side now, RX side later).
// Holds the FSM state encodings and the parity-mode constants.
package parity_serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

endpackage

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: serial parity frame transmitter.
// Accepts a DATA_W-bit word over valid/ready and sends it LSB-first on x,
// one bit per clk, followed by one parity bit (even or odd per ODD_PARITY).
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   data_in      word to transmit, sampled on accept
//   valid_in     source has a word on data_in
//   ready_out    block can accept a word this cycle (decoded from state)
//   x            serial line: data bits then parity bit (registered)
//   frame_active high while x carries a data or parity bit (registered)
//   parity_slot  high only while x carries the parity bit (registered)
//   done         one-cycle pulse in the cycle after the parity bit (registered)
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | waiting for a word; ready_out high, x low
// ST_DATA   | shifting data bits out, LSB first
// ST_PARITY | driving the parity bit for the frame just sent
module parity_serial_tx
    import parity_serial_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = PAR_EVEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              x,
    output logic              frame_active,
    output logic              parity_slot,
    output logic              done
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic            PAR_FILL = (ODD_PARITY == PAR_ODD);

    state_t              state_q, state_nxt;
    logic [DATA_W-1:0]   shift_q, shift_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic                acc_q, acc_nxt;

    logic x_nxt, frame_active_nxt, parity_slot_nxt, done_nxt;
    logic accept;

    assign ready_out = (state_q == ST_IDLE);
    assign accept    = valid_in && ready_out;

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            x            <= 1'b0;
            frame_active <= 1'b0;
            parity_slot  <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            shift_q      <= shift_nxt;
            cnt_q        <= cnt_nxt;
            acc_q        <= acc_nxt;
            x            <= x_nxt;
            frame_active <= frame_active_nxt;
            parity_slot  <= parity_slot_nxt;
            done         <= done_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state_q;
        shift_nxt = shift_q;
        cnt_nxt   = cnt_q;
        acc_nxt   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_nxt = data_in;
                    cnt_nxt   = '0;
                    acc_nxt   = 1'b0;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                acc_nxt   = acc_q ^ shift_q[0];
                shift_nxt = {1'b0, shift_q[DATA_W-1:1]};
                if (cnt_q == CNT_LAST) begin
                    state_nxt = ST_PARITY;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next-cycle values and registered, so the
    // line reflects shift_q[0] / the accumulated parity of the cycle it is in.
    always_comb begin
        x_nxt            = 1'b0;
        frame_active_nxt = (state_nxt != ST_IDLE);
        parity_slot_nxt  = (state_nxt == ST_PARITY);
        done_nxt         = (state_q == ST_PARITY);
        case (state_nxt)
            ST_DATA:   x_nxt = shift_nxt[0];
            ST_PARITY: x_nxt = acc_nxt ^ PAR_FILL;
            default:   x_nxt = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: one even-parity and one odd-parity
// instance driven with the same stimulus and checked cycle by cycle.
module tb_parity_serial_tx;
    import parity_serial_tx_pkg::*;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] data_in;
    logic              valid_in;

    logic ready_e, x_e, fa_e, ps_e, done_e;
    logic ready_o, x_o, fa_o, ps_o, done_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t1, t2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    parity_serial_tx #(.DATA_W(DATA_W), .ODD_PARITY(PAR_EVEN)) dut_even (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_e),
        .x            (x_e),
        .frame_active (fa_e),
        .parity_slot  (ps_e),
        .done         (done_e)
    );

    parity_serial_tx #(.DATA_W(DATA_W), .ODD_PARITY(PAR_ODD)) dut_odd (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_o),
        .x            (x_o),
        .frame_active (fa_o),
        .parity_slot  (ps_o),
        .done         (done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output vector order: {ready_out, x, frame_active, parity_slot, done}
    task automatic check_idle(input string tag);
        chk({tag, " even"}, {27'd0, ready_e, x_e, fa_e, ps_e, done_e}, 32'b10000);
        chk({tag, " odd"},  {27'd0, ready_o, x_o, fa_o, ps_o, done_o}, 32'b10000);
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        data_in  = d;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        data_in  = ~d;
    endtask

    // Starts at the negedge of the first data cycle, ends at the done cycle.
    task automatic check_frame(input logic [DATA_W-1:0] d, input logic par_even,
                               input string tag);
        int ones_e = 0;
        int ones_o = 0;
        for (int i = 0; i < DATA_W; i++) begin
            chk($sformatf("%s bit%0d even", tag, i),
                {27'd0, ready_e, x_e, fa_e, ps_e, done_e},
                {27'd0, 1'b0, d[i], 1'b1, 1'b0, 1'b0});
            chk($sformatf("%s bit%0d odd", tag, i),
                {27'd0, ready_o, x_o, fa_o, ps_o, done_o},
                {27'd0, 1'b0, d[i], 1'b1, 1'b0, 1'b0});
            ones_e += int'(x_e);
            ones_o += int'(x_o);
            @(negedge clk);
        end
        chk({tag, " parity even"}, {27'd0, ready_e, x_e, fa_e, ps_e, done_e},
            {27'd0, 1'b0, par_even, 1'b1, 1'b1, 1'b0});
        chk({tag, " parity odd"}, {27'd0, ready_o, x_o, fa_o, ps_o, done_o},
            {27'd0, 1'b0, ~par_even, 1'b1, 1'b1, 1'b0});
        ones_e += int'(x_e);
        ones_o += int'(x_o);
        @(negedge clk);
        chk({tag, " done even"}, {27'd0, ready_e, x_e, fa_e, ps_e, done_e}, 32'b10001);
        chk({tag, " done odd"},  {27'd0, ready_o, x_o, fa_o, ps_o, done_o}, 32'b10001);
        chk({tag, " frame ones even"}, 32'(ones_e % 2), 32'd0);
        chk({tag, " frame ones odd"},  32'(ones_o % 2), 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        #3;
        check_idle("in reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle c%0d", i));
        end

        send(8'hA5);
        check_frame(8'hA5, 1'b0, "a5");
        send(8'h07);
        check_frame(8'h07, 1'b1, "07");
        send(8'h00);
        check_frame(8'h00, 1'b0, "00");
        send(8'hFF);
        check_frame(8'hFF, 1'b0, "ff");

        // Back-to-back: valid held high, data changes while frame 1 is in flight.
        data_in  = 8'h3C;
        valid_in = 1'b1;
        @(negedge clk);
        t1      = cyc;
        data_in = 8'hC3;
        check_frame(8'h3C, 1'b0, "b2b first");
        @(negedge clk);
        t2       = cyc;
        valid_in = 1'b0;
        chk("accept spacing", 32'(t2 - t1), 32'd10);
        check_frame(8'hC3, 1'b0, "b2b second");

        // Reset pulsed in the middle of a frame.
        @(negedge clk);
        send(8'hA5);
        repeat (4) @(negedge clk);
        chk("pre abort active", {31'd0, fa_e}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_idle("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("post abort c%0d", i));
        end
        send(8'h01);
        check_frame(8'h01, 1'b1, "01");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
